// File: rtl/fbcpu_pkg.sv
// Shared definitions for the FBCPU boot loader: loader state encoding
// and default RAM/stream width constants.
package fbcpu_pkg;

   localparam int DEF_AW = 6;
   localparam int DEF_DW = 10;

   typedef enum logic [2:0] {
      ST_LEN,
      ST_LOAD,
      ST_CHK,
      ST_RUN,
      ST_ERR
   } state_t;

endpackage

// File: rtl/fbcpu_boot_mux.sv
// RAM port select: loader write port or FBCPU port onto the blram inputs.
// Ports: sel_cpu picks cpu_*; ld_* loader side; ram_* to blram.
import fbcpu_pkg::*;

module fbcpu_boot_mux #(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          sel_cpu,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we
);

   always_comb begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = ld_we;
      if (sel_cpu) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we    = cpu_we;
      end
   end

endmodule

// File: rtl/fbcpu_boot_loader.sv
// Boot loader: takes a length header plus program words from a valid/ready
// stream, writes them to blram from address 0 with FBCPU held in reset,
// then hands the RAM port to FBCPU.
// Ports: clk, rst (sync, active-low); s_valid/s_data/s_ready stream in;
// cpu_rst to FBCPU; cpu_addr/cpu_wdata/cpu_we from FBCPU;
// ram_addr/ram_wdata/ram_we to blram; done, error status.
// Option: define FBCPU_BOOT_CHECKSUM_EN to require a trailing checksum word.
import fbcpu_pkg::*;

module fbcpu_boot_loader #(
   parameter int ADDRESS_WIDTH = DEF_AW,
   parameter int DATA_WIDTH    = DEF_DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   input  logic [DATA_WIDTH-1:0]    s_data,
   output logic                     s_ready,
   output logic                     cpu_rst,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   input  logic                     cpu_we,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_wdata,
   output logic                     ram_we,
   output logic                     done,
   output logic                     error
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int CW    = AW + 1;
   localparam int DEPTH = 2 ** AW;

   state_t state, state_nx;

   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_we;
   logic [31:0]   hdr;
   logic          hdr_bad;
   logic          is_last;
   logic          xfer;
   logic          sel_cpu;

`ifdef FBCPU_BOOT_CHECKSUM_EN
   logic [DW-1:0] sum;
`endif

   assign hdr     = 32'(s_data);
   assign hdr_bad = hdr > 32'(DEPTH);
   assign is_last = cnt == last;
   assign xfer    = s_valid & s_ready;

   // The final data word is still pending in ld_* during the first RUN
   // cycle; keep the loader on the port until that write has landed.
   assign sel_cpu = (state == ST_RUN) && !ld_we;

   always_comb begin
      state_nx = state;
      s_ready  = 1'b0;
      cpu_rst  = 1'b1;
      done     = 1'b0;
      error    = 1'b0;
      unique case (state)
         ST_LEN: begin
            s_ready = rst;
            if (xfer)
               state_nx = hdr_bad ? ST_ERR : ST_LOAD;
         end
         ST_LOAD: begin
            s_ready = rst;
            if (xfer && is_last)
`ifdef FBCPU_BOOT_CHECKSUM_EN
               state_nx = ST_CHK;
`else
               state_nx = ST_RUN;
`endif
         end
         ST_CHK: begin
`ifdef FBCPU_BOOT_CHECKSUM_EN
            s_ready = rst;
            if (xfer)
               state_nx = (s_data == sum) ? ST_RUN : ST_ERR;
`else
            state_nx = ST_ERR;
`endif
         end
         ST_RUN: begin
            cpu_rst = 1'b0;
            done    = 1'b1;
         end
         ST_ERR: begin
            error = 1'b1;
         end
         default: state_nx = ST_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_LEN;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt      <= '0;
         last     <= '0;
         ld_we    <= 1'b0;
         ld_addr  <= '0;
         ld_wdata <= '0;
`ifdef FBCPU_BOOT_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         ld_we <= 1'b0;
         if (state == ST_LEN && xfer) begin
            cnt <= '0;
            // Header 0 means a full-depth image.
            last <= (hdr == 32'd0) ? CW'(DEPTH - 1) : CW'(hdr - 32'd1);
`ifdef FBCPU_BOOT_CHECKSUM_EN
            sum <= '0;
`endif
         end
         if (state == ST_LOAD && xfer) begin
            ld_we    <= 1'b1;
            ld_addr  <= cnt[AW-1:0];
            ld_wdata <= s_data;
            cnt      <= cnt + 1'b1;
`ifdef FBCPU_BOOT_CHECKSUM_EN
            sum      <= sum + s_data;
`endif
         end
      end
   end

   fbcpu_boot_mux #(
      .AW(AW),
      .DW(DW)
   ) u_mux (
      .sel_cpu   (sel_cpu),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_we     (ld_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we)
   );

endmodule
